reg_file: RTL

Architectural register file with rename tags for the out-of-order core. Holds the 32 committed integer registers plus, per register, a busy bit and the ROB entry that will produce its next value. Sits beside the decoder/issue stage. It takes register pollution on issue and register writes on commit from the ROB. It resolves source operands for the instruction being issued by querying the ROB's two lookup ports and bypassing the same-cycle commit.

---
 rtl/reg_file.sv | 130 +++++++++++++
 1 files changed

// File: rtl/reg_file.sv
// Architectural register file with per-register rename tags (busy + producing ROB entry).
// Resolves issue-stage operands from committed state, same-cycle commit bypass, or ROB lookup.
module reg_file #(
    parameter int ROB_BIT = 4,
    parameter int REG_BIT = 5
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               clear_up,
    input  logic               issue_pollute,
    input  logic [REG_BIT-1:0] issue_reg_id,
    input  logic [ROB_BIT-1:0] issue_rob_entry,
    input  logic               rob_commit,
    input  logic [REG_BIT-1:0] commit_rd_reg_id,
    input  logic [ROB_BIT-1:0] commit_rob_entry,
    input  logic [31:0]        commit_value,
    input  logic [REG_BIT-1:0] rs1_id,
    input  logic [REG_BIT-1:0] rs2_id,
    output logic [ROB_BIT-1:0] get_rob_entry1,
    output logic [ROB_BIT-1:0] get_rob_entry2,
    input  logic               ready1,
    input  logic               ready2,
    input  logic [31:0]        value1,
    input  logic [31:0]        value2,
    output logic               rs1_ready,
    output logic               rs2_ready,
    output logic [31:0]        rs1_value,
    output logic [31:0]        rs2_value,
    output logic [ROB_BIT-1:0] rs1_rob_entry,
    output logic [ROB_BIT-1:0] rs2_rob_entry,
    output logic [31:0]        commit_cnt
);

    localparam int NUM_REGS = 1 << REG_BIT;

    logic [31:0]          regs_q [NUM_REGS];
    logic [31:0]          regs_d [NUM_REGS];
    logic [ROB_BIT-1:0]   tag_q  [NUM_REGS];
    logic [ROB_BIT-1:0]   tag_d  [NUM_REGS];
    logic [NUM_REGS-1:0]  busy_q, busy_d;
    logic [31:0]          commit_cnt_q, commit_cnt_d;

    // Commit first, then issue (so issue wins on the same rd), then flush.
    always_comb begin
        regs_d       = regs_q;
        tag_d        = tag_q;
        busy_d       = busy_q;
        commit_cnt_d = commit_cnt_q;
        if (rdy_in) begin
            if (rob_commit) begin
                commit_cnt_d = commit_cnt_q + 32'd1;
                if (commit_rd_reg_id != '0) begin
                    regs_d[commit_rd_reg_id] = commit_value;
                    if (busy_q[commit_rd_reg_id] && (tag_q[commit_rd_reg_id] == commit_rob_entry)) begin
                        busy_d[commit_rd_reg_id] = 1'b0;
                    end
                end
            end
            if (clear_up) begin
                busy_d = '0;
                for (int i = 0; i < NUM_REGS; i++) begin
                    tag_d[i] = '0;
                end
            end else if (issue_pollute && (issue_reg_id != '0)) begin
                busy_d[issue_reg_id] = 1'b1;
                tag_d[issue_reg_id]  = issue_rob_entry;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
                tag_q[i]  <= '0;
            end
            busy_q       <= '0;
            commit_cnt_q <= '0;
        end else begin
            regs_q       <= regs_d;
            tag_q        <= tag_d;
            busy_q       <= busy_d;
            commit_cnt_q <= commit_cnt_d;
        end
    end

    // Returns {ready, value} for one source port.
    function automatic logic [32:0] resolve(
        input logic [REG_BIT-1:0] id,
        input logic               busy,
        input logic [ROB_BIT-1:0] tag,
        input logic [31:0]        regv,
        input logic               cm_valid,
        input logic [REG_BIT-1:0] cm_rd,
        input logic [ROB_BIT-1:0] cm_entry,
        input logic [31:0]        cm_value,
        input logic               lk_ready,
        input logic [31:0]        lk_value
    );
        logic [32:0] res;
        res = {1'b0, 32'd0};
        if (id == '0) begin
            res = {1'b1, 32'd0};
        end else if (!busy) begin
            res = {1'b1, regv};
        end else if (cm_valid && (cm_rd == id) && (cm_entry == tag)) begin
            res = {1'b1, cm_value};
        end else if (lk_ready) begin
            res = {1'b1, lk_value};
        end
        return res;
    endfunction

    always_comb begin
        {rs1_ready, rs1_value} = resolve(rs1_id, busy_q[rs1_id], tag_q[rs1_id], regs_q[rs1_id],
                                         rob_commit, commit_rd_reg_id, commit_rob_entry,
                                         commit_value, ready1, value1);
        {rs2_ready, rs2_value} = resolve(rs2_id, busy_q[rs2_id], tag_q[rs2_id], regs_q[rs2_id],
                                         rob_commit, commit_rd_reg_id, commit_rob_entry,
                                         commit_value, ready2, value2);
    end

    assign get_rob_entry1 = tag_q[rs1_id];
    assign get_rob_entry2 = tag_q[rs2_id];
    assign rs1_rob_entry  = tag_q[rs1_id];
    assign rs2_rob_entry  = tag_q[rs2_id];
    assign commit_cnt     = commit_cnt_q;

endmodule
